// File: rtl/day7_xor_using_decoder.sv
// XOR built from a 2-to-4 decoder (f = y[1] | y[2]), with registered copies,
// a saturating count of f-high edges and a sticky decoder self-check flag.
module day7_xor_using_decoder #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             e,
  input  logic             a,
  input  logic             b,
  output logic             f,
  input  logic             clk,
  input  logic             rst,
  output logic [3:0]       y,
  output logic             f_q,
  output logic [3:0]       y_q,
  output logic [CNT_W-1:0] f_cnt,
  output logic             chk_err
);

  logic f_direct;
  logic multi_hot;
  logic mismatch;

  always_comb begin
    y = '0;
    if (e) begin
      unique case ({a, b})
        2'b00:   y = 4'b0001;
        2'b01:   y = 4'b0010;
        2'b10:   y = 4'b0100;
        default: y = 4'b1000;
      endcase
    end
  end

  assign f = y[1] | y[2];

  // Independent reference path; any disagreement with the decoder is latched.
  assign f_direct  = e & (a ^ b);
  assign multi_hot = |(y & (y - 4'd1));
  assign mismatch  = (f != f_direct) | multi_hot;

  always_ff @(posedge clk) begin
    if (rst) begin
      f_q     <= 1'b0;
      y_q     <= '0;
      f_cnt   <= '0;
      chk_err <= 1'b0;
    end else begin
      f_q <= f;
      y_q <= y;
      if (f && (f_cnt != '1))
        f_cnt <= f_cnt + CNT_W'(1);
      if (mismatch)
        chk_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_day7_xor_using_decoder.sv
// Directed bench for day7_xor_using_decoder: default-width instance plus a
// CNT_W=2 instance sharing the same stimulus to exercise counter saturation.
module tb_day7_xor_using_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       e = 1'b0;
  logic       a = 1'b0;
  logic       b = 1'b0;

  logic       f, f2;
  logic [3:0] y, y2;
  logic       f_q, f_q2;
  logic [3:0] y_q, y_q2;
  logic [7:0] f_cnt;
  logic [1:0] f_cnt2;
  logic       chk_err, chk_err2;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  day7_xor_using_decoder dut (
    .e(e), .a(a), .b(b), .f(f), .clk(clk), .rst(rst), .y(y),
    .f_q(f_q), .y_q(y_q), .f_cnt(f_cnt), .chk_err(chk_err)
  );

  day7_xor_using_decoder #(.CNT_W(2)) dut_w2 (
    .e(e), .a(a), .b(b), .f(f2), .clk(clk), .rst(rst), .y(y2),
    .f_q(f_q2), .y_q(y_q2), .f_cnt(f_cnt2), .chk_err(chk_err2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic ne, input logic na, input logic nb);
    @(negedge clk);
    e = ne;
    a = na;
    b = nb;
  endtask

  logic [3:0] y_tab [4];
  logic       f_tab [4];
  int unsigned exp_cnt;
  logic        exp_f;
  logic [3:0]  exp_y;
  logic [2:0]  v;

  initial begin
    y_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    f_tab = '{1'b0, 1'b1, 1'b1, 1'b0};

    // Combinational response, enabled then disabled
    for (int unsigned i = 0; i < 4; i++) begin
      drive(1'b1, i[1], i[0]);
      #1;
      check("f_en", 32'(f), 32'(f_tab[i]));
      check("y_en", 32'(y), 32'(y_tab[i]));
      #9;
    end
    for (int unsigned i = 0; i < 4; i++) begin
      drive(1'b0, i[1], i[0]);
      #1;
      check("f_dis", 32'(f), 32'h0);
      check("y_dis", 32'(y), 32'h0);
    end

    // Reset held 2 edges while f=1
    drive(1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_f_q", 32'(f_q), 32'h0);
    check("rst_y_q", 32'(y_q), 32'h0);
    check("rst_f_cnt", 32'(f_cnt), 32'h0);
    check("rst_chk_err", 32'(chk_err), 32'h0);
    check("rst_f_comb", 32'(f), 32'h1);
    check("rst_y_comb", 32'(y), 32'h2);
    check("rst_f_cnt_w2", 32'(f_cnt2), 32'h0);

    // Hold ab=10 enabled for 5 edges
    drive(1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("hold_f_q_first", 32'(f_q), 32'h1);
    check("hold_y_q_first", 32'(y_q), 32'h4);
    check("hold_cnt_first", 32'(f_cnt), 32'h1);
    repeat (4) @(posedge clk);
    #1;
    check("hold_f_cnt5", 32'(f_cnt), 32'd5);
    check("hold_chk_err", 32'(chk_err), 32'h0);
    check("w2_cnt_5edges", 32'(f_cnt2), 32'd3);
    @(posedge clk);
    #1;
    check("hold_f_cnt6", 32'(f_cnt), 32'd6);
    check("w2_cnt_saturated", 32'(f_cnt2), 32'd3);

    // Two sweeps of all input combinations
    exp_cnt = 6;
    for (int unsigned s = 0; s < 2; s++) begin
      for (int unsigned k = 0; k < 8; k++) begin
        v = k[2:0];
        drive(v[2], v[1], v[0]);
        exp_f = v[2] & (v[1] ^ v[0]);
        exp_y = v[2] ? (4'd1 << v[1:0]) : 4'd0;
        @(posedge clk);
        #1;
        if (exp_f) exp_cnt++;
        check("sweep_f_q", 32'(f_q), 32'(exp_f));
        check("sweep_y_q", 32'(y_q), 32'(exp_y));
      end
      check("sweep_f_cnt", 32'(f_cnt), 32'(exp_cnt));
      check("sweep_chk_err", 32'(chk_err), 32'h0);
    end
    check("sweep_total", 32'(f_cnt), 32'd10);
    check("w2_sweep_sat", 32'(f_cnt2), 32'd3);

    // Mid-operation reset with f=1: reset wins, counter restarts
    drive(1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_cnt", 32'(f_cnt), 32'h0);
    check("mid_rst_f_q", 32'(f_q), 32'h0);
    check("mid_rst_f", 32'(f), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("resume_cnt", 32'(f_cnt), 32'h1);
    check("resume_f_q", 32'(f_q), 32'h1);
    check("resume_y_q", 32'(y_q), 32'h2);
    check("resume_chk_err", 32'(chk_err), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
